// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: request/result bundle between the ALU issue logic and the
// multiply sequencer.
//   req_valid/req_ready  request handshake
//   req_op               00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_rs1/req_rs2      operands
//   req_tag              destination tag carried with the request
//   flush                discard in-flight/pending op, invalidate cache
//   res_valid/res_ready  result handshake
//   res_data/res_tag     selected product half and its tag
// master = issue side, slave = controller.
interface mul_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             res_valid;
  logic             res_ready;
  logic [XLEN-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag, flush, res_ready,
    input  req_ready, res_valid, res_data, res_tag
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag, flush, res_ready,
    output req_ready, res_valid, res_data, res_tag
  );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl: RV32M multiply sequencer between issue logic and the booth
// multiplier. Decodes MUL/MULH/MULHSU/MULHU, launches the multiplier,
// captures the product on its valid pulse and returns the selected half.
// A one-entry product cache lets a MULH*/MUL pair on the same operands
// use the multiplier only once. Flush drains an in-flight multiply.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus               request/result interface (slave side)
//   mul_start         one-cycle start pulse to the multiplier
//   mul_x_signed/_y   operand signedness
//   mul_x, mul_y      operands, stable from start until mul_valid
//   mul_valid, mul_z  one-cycle product-ready pulse and 2*XLEN product
module mul_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_ctrl_if.slave         bus,
  output logic              mul_start,
  output logic              mul_x_signed,
  output logic              mul_y_signed,
  output logic [XLEN-1:0]   mul_x,
  output logic [XLEN-1:0]   mul_y,
  input  logic              mul_valid,
  input  logic [2*XLEN-1:0] mul_z
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b11;

  logic [2:0]       state;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;

  logic              cache_valid;
  logic [XLEN-1:0]   cache_rs1;
  logic [XLEN-1:0]   cache_rs2;
  logic              cache_xs;
  logic              cache_ys;
  logic [2*XLEN-1:0] cache_prod;

  logic             res_valid_q;
  logic [XLEN-1:0]  res_data_q;
  logic [TAG_W-1:0] res_tag_q;

  logic accept;
  logic req_xs;
  logic req_ys;
  logic hit;

  // MUL takes the low half; every high-half op takes the upper word.
  function automatic logic [XLEN-1:0] select_half(input logic [1:0] op,
                                                  input logic [2*XLEN-1:0] prod);
    if (op == OP_MUL) return prod[XLEN-1:0];
    return prod[2*XLEN-1:XLEN];
  endfunction

  // Held low while in reset so upstream never sees a stray accept.
  assign bus.req_ready = rst_n && (state == S_IDLE) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;

  // Only MULHU treats rs1 as unsigned; rs2 is signed for MUL and MULH.
  assign req_xs = (bus.req_op != OP_MULHU);
  assign req_ys = !bus.req_op[1];

  // The low half does not depend on signedness, so MUL ignores the flags.
  assign hit = cache_valid && (bus.req_rs1 == cache_rs1) && (bus.req_rs2 == cache_rs2) &&
               ((bus.req_op == OP_MUL) || ((req_xs == cache_xs) && (req_ys == cache_ys)));

  assign mul_start     = (state == S_LAUNCH);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_q         <= OP_MUL;
      tag_q        <= '0;
      mul_x        <= '0;
      mul_y        <= '0;
      mul_x_signed <= 1'b0;
      mul_y_signed <= 1'b0;
      cache_valid  <= 1'b0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_xs     <= 1'b0;
      cache_ys     <= 1'b0;
      cache_prod   <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_tag_q    <= '0;
    end else begin
      if (bus.flush) cache_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q         <= bus.req_op;
            tag_q        <= bus.req_tag;
            mul_x        <= bus.req_rs1;
            mul_y        <= bus.req_rs2;
            mul_x_signed <= req_xs;
            mul_y_signed <= req_ys;
            if (hit) begin
              res_valid_q <= 1'b1;
              res_data_q  <= select_half(bus.req_op, cache_prod);
              res_tag_q   <= bus.req_tag;
              state       <= S_DONE;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end

        // The start pulse goes out this cycle regardless of flush, so a
        // flush here still has to wait out the multiplier.
        S_LAUNCH: begin
          state <= bus.flush ? S_DRAIN : S_WAIT;
        end

        S_WAIT: begin
          if (bus.flush) begin
            state <= mul_valid ? S_IDLE : S_DRAIN;
          end else if (mul_valid) begin
            cache_valid <= 1'b1;
            cache_rs1   <= mul_x;
            cache_rs2   <= mul_y;
            cache_xs    <= mul_x_signed;
            cache_ys    <= mul_y_signed;
            cache_prod  <= mul_z;
            res_valid_q <= 1'b1;
            res_data_q  <= select_half(op_q, mul_z);
            res_tag_q   <= tag_q;
            state       <= S_DONE;
          end
        end

        S_DONE: begin
          if (bus.flush || bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end

        // Flushed product is thrown away and never reaches the cache.
        S_DRAIN: begin
          if (mul_valid) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
Sequencer sitting between the ALU issue logic and the booth multiplier. It decodes RV32M multiply ops (MUL/MULH/MULHSU/MULHU) and drives operands and signedness into the multiplier. It captures the 64-bit product on the multiplier's one-cycle valid pulse and returns the selected 32-bit half through a valid/ready result port. It also keeps a one-entry product cache so a MULH[S[U]]+MUL pair on the same operands issues the multiplier once, and it handles flush while a multiply is in flight.

Parameters:
XLEN, core_config_pkg::XLEN (32), operand width; product is 2*XLEN.
TAG_W, 5, width of destination tag carried with each request.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
req_rs1  in  XLEN  multiplicand.
req_rs2  in  XLEN  multiplier.
req_tag  in  TAG_W  destination tag.
flush  in  1  discard in-flight/pending op, invalidate cache.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts result.
res_data  out  XLEN  selected product half.
res_tag  out  TAG_W  tag of the result.
mul_start  out  1  one-cycle start pulse to multiplier.
mul_x_signed  out  1  rs1 signedness.
mul_y_signed  out  1  rs2 signedness.
mul_x  out  XLEN  operand X, held stable from start until mul_valid.
mul_y  out  XLEN  operand Y, held stable from start until mul_valid.
mul_valid  in  1  one-cycle product-ready pulse.
mul_z  in  2*XLEN  product; only guaranteed during the mul_valid cycle.

Behaviour:
- Reset (async, any state): state IDLE, req_ready=0 during reset then 1, res_valid=0, res_data=0, res_tag=0, mul_start=0, mul_x/mul_y=0, signed flags=0, cache invalid.
- States: IDLE, LAUNCH, WAIT, DONE, DRAIN.
- req_ready=1 only in IDLE with flush=0. Accept = req_valid & req_ready; on accept, register op, rs1, rs2, tag.
- Signedness: MUL s/s, MULH s/s, MULHSU X signed/Y unsigned, MULHU u/u.
- Cache hit check at accept; the entry holds rs1, rs2, x_signed, y_signed, and the 64-bit product:
  - MUL hits if rs1 and rs2 match, regardless of stored signedness (low half is sign-independent).
  - MULH/MULHSU/MULHU hit only if rs1, rs2 and both signed flags match.
- Hit: IDLE -> DONE. res_valid=1 the cycle after accept; no mul_start.
- Miss: IDLE -> LAUNCH. In LAUNCH, mul_start=1 for exactly one cycle, then -> WAIT. mul_x, mul_y and the signed flags stay constant from LAUNCH until mul_valid.
- WAIT, on mul_valid: latch mul_z into the cache with operands and flags (cache valid), compute res_data, -> DONE. res_valid rises the cycle after mul_valid. Miss latency is accept-to-res_valid = multiplier latency + 2 cycles.
- res_data: MUL = product[XLEN-1:0]; all others = product[2*XLEN-1:XLEN].
- DONE: res_valid, res_data and res_tag are held stable until res_ready. res_valid & res_ready -> IDLE. A new request can be accepted the cycle after the handshake.
- flush:
  - Always invalidates the cache.
  - In LAUNCH or WAIT (multiplier cannot abort): -> DRAIN. Wait for mul_valid, discard the product, do not update the cache, -> IDLE.
  - In DONE: drop the result (res_valid=0 next cycle) -> IDLE.
  - In IDLE: no request is accepted that cycle.
  - mul_valid coinciding with flush in WAIT: product discarded -> IDLE.
- mul_valid outside WAIT/DRAIN is ignored.
- Cache is never written with a product whose op was flushed.

Test Plan:
- Reset mid-WAIT (rst_n low 1 cycle) -> res_valid=0, mul_start=0, req_ready=1 after release. A following MUL of the same operands misses (issues mul_start).
- MULH rs1=0xFFFFFFF9, rs2=0x00000003 -> one mul_start pulse, mul_x_signed=mul_y_signed=1, res_data=0xFFFFFFFF, res_tag echoes req_tag.
- Then MUL with same operands -> no mul_start, res_valid 1 cycle after accept, res_data=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> res_data=0xFFFFFFFE. Then MULHSU with the same operands -> cache miss (flags differ), res_data=0xFFFFFFFF.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> res_data and res_tag stable, req_ready=0 throughout. Release -> IDLE next cycle.
- flush 5 cycles after mul_start -> no res_valid for that op, req_ready stays 0 until the mul_valid pulse, then 1. Repeating the same op misses the cache.
